piso_shifter: RTL and testbench
===============================

# piso_shifter

Parallel-in, serial-out shifter. It accepts an n-bit word through a valid/ready load handshake and presents it LSB-first, one bit per cycle, on a serial output with valid/ready flow control. It is the transmit end of the team's serial datapath: the word held in an n-bit register is serialized here and rebuilt by the deserializing receiver at the far end. Back-to-back words stream with no idle gap.

## Interface
- n, 8: word width in bits, n >= 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- d  input  n  parallel word to transmit.
- load_valid  input  1  d is valid this cycle.
- load_ready  output  1  shifter accepts d this cycle.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a valid bit.
- sout_ready  input  1  downstream consumes sout this cycle.
- last  output  1  sout is bit n-1 of the current word.

## Operation
- State register with two states, IDLE and SHIFT. Internal registers:
  - shreg, n bits.
  - cnt, $clog2(n) bits: index of the bit currently on sout.
- A load occurs on `load_valid && load_ready`. Output handshakes are the same: a bit is consumed on `sout_valid && sout_ready`.
- IDLE:
  - Outputs: load_ready=1, sout_valid=0, last=0.
  - On load: shreg<=d, cnt<=0, go to SHIFT.
- SHIFT:
  - Outputs: sout=shreg[0], sout_valid=1, last=(cnt==n-1).
  - Bit consumed with cnt<n-1: shreg shifts right (zero fill), cnt<=cnt+1.
  - Bit consumed with cnt==n-1 and a load in the same cycle: shreg<=d, cnt<=0, stay in SHIFT. This is the zero-gap handoff.
  - Bit consumed with cnt==n-1 and no load: go to IDLE, cnt<=0.
  - sout_ready low: shreg, cnt and state hold, and sout, sout_valid and last stay stable.
- load_ready = (state==IDLE) || (state==SHIFT && cnt==n-1 && sout_ready).
  - load_ready is combinational from state, cnt and sout_ready.
  - In SHIFT, load_valid is ignored unless load_ready is high; d is not sampled otherwise.
- sout, sout_valid and last are decoded from registered state only. There is no combinational path from d or load_valid to the serial outputs.
- Wrap-around: cnt never exceeds n-1. For non-power-of-2 n, cnt values above n-1 are unreachable and are not decoded.

## Timing
- Reset is synchronous with priority over everything else. After the rst edge:
  - state=IDLE, shreg=0, cnt=0.
  - sout=0, sout_valid=0, last=0, load_ready=1.
- Reset mid-word: the word is discarded, and sout_valid=0 from the cycle after the rst edge.
- Latency: a word loaded at edge E drives bit 0 on sout in the cycle starting at E.
- With sout_ready held at 1:
  - Bit i is on sout in cycle E+i.
  - last is high in cycle E+n-1.
- Throughput: one bit per cycle. Back-to-back words give n*k contiguous valid cycles for k words.
- Each cycle with sout_ready low stretches the word by exactly one cycle.

## Structure
- Shared package `serial_pkg` holds:
  - state localparams IDLE=1'b0 and SHIFT=1'b1;
  - the count width function CNT_W(n)=$clog2(n). The receiver uses the same package.
- One sub-module, `mod_counter`: parameterized modulus-n up-counter with enable and synchronous clear. Its outputs are the count and a terminal flag (cnt==n-1), which drives last.
- shreg and the FSM stay in the top module.

## Test plan
- **Single word:** n=8, load d=8'hA5 once, sout_ready=1.
  - sout = 1,0,1,0,0,1,0,1 over 8 consecutive cycles.
  - last high only on the 8th cycle, then sout_valid=0 and load_ready=1.
- **Back-to-back:** load 8'hA5, then hold load_valid=1 with d=8'h3C.
  - 16 contiguous sout_valid cycles; the second word is 0,0,1,1,1,1,0,0.
  - load_ready is high only in the 8th cycle of the first word.
- **Backpressure:** load 8'hA5 and drop sout_ready for 3 cycles while bit 2 is on sout.
  - sout=1 and last=0 held for those 3 cycles.
  - The word completes in 11 cycles with the bit sequence unchanged.
- **Busy load ignored:** assert load_valid with d=8'hFF while cnt is between 1 and 6.
  - Transmitted bits still match 8'hA5.
  - load_ready stays low until cnt=7.
- **Reset mid-word:** assert rst for one cycle after bit 3 of 8'hA5.
  - Next cycle: sout_valid=0, sout=0, last=0, load_ready=1.
  - A subsequent load of 8'h01 gives 1,0,0,0,0,0,0,0.
- **Minimum width:** n=2, load 2'b10 then 2'b01 back-to-back.
  - sout = 0,1,1,0.
  - last high on the 2nd and 4th cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and count width helper shared by the serial transmitter and receiver
package serial_pkg;
    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;
    function automatic int CNT_W(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulus-n up-counter with enable, synchronous clear and terminal flag
module mod_counter
    import serial_pkg::*;
#(
    parameter int n = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    output logic [CNT_W(n)-1:0]   cnt,
    output logic                  term
);
    localparam int w = CNT_W(n);
    localparam logic [w-1:0] cmax = w'(n - 1);
    assign term = cnt == cmax;
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= term ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in serial-out shifter, LSB first, valid/ready on load and serial sides
module piso_shifter
    import serial_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] d,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         sout,
    output logic         sout_valid,
    input  logic         sout_ready,
    output logic         last
);
    localparam int w = CNT_W(n);
    localparam logic [w-1:0] cmax = w'(n - 1);
    logic         state;
    logic [n-1:0] shreg;
    logic [w-1:0] cnt;
    logic         term;
    logic         fire;
    logic         load;
    assign fire       = state == SHIFT && sout_ready;
    // accepting on the final consumed bit lets words stream with no idle cycle
    assign load_ready = state == IDLE || (cnt == cmax && sout_ready);
    assign load       = load_valid && load_ready;
    assign sout       = state == SHIFT && shreg[0];
    assign sout_valid = state == SHIFT;
    assign last       = state == SHIFT && term;
    mod_counter #(.n(n)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (fire),
        .clr  (load),
        .cnt  (cnt),
        .term (term)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
        end else if (load) begin
            state <= SHIFT;
            shreg <= d;
        end else if (fire) begin
            state <= term ? IDLE : SHIFT;
            shreg <= shreg >> 1;
        end
    end
endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: directed and random checks of n=8 and n=2 shifters against a word/bit-index model
module tb_piso_shifter;
    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic       sout_ready;
    logic [7:0] d;
    wire  [1:0] so, sv, sl, lr;
    int         n_assert = 0;
    int         n_fail = 0;
    bit         on = 1'b0;
    int         nw [2] = '{8, 2};
    logic [7:0] mw [2];
    int         mi [2];
    int         mr [2];
    logic [15:0] cap [2];
    int         capn [2];
    int         vcnt [2];

    always #5 clk = ~clk;

    piso_shifter #(.n(8)) u8 (
        .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(lr[0]),
        .sout(so[0]), .sout_valid(sv[0]), .sout_ready(sout_ready), .last(sl[0])
    );
    piso_shifter #(.n(2)) u2 (
        .clk(clk), .rst(rst), .d(d[1:0]), .load_valid(load_valid), .load_ready(lr[1]),
        .sout(so[1]), .sout_valid(sv[1]), .sout_ready(sout_ready), .last(sl[1])
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            cap[k] = '0;
            capn[k] = 0;
            vcnt[k] = 0;
        end
    endtask

    // model: mr = bits of the current word still to be consumed, mi = index of the bit on sout
    task automatic step(input logic lv, input logic [7:0] dd, input logic sr, input logic r);
        logic fire, ld;
        load_valid = lv;
        d = dd;
        sout_ready = sr;
        rst = r;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (on) begin
                chk($sformatf("sout_valid n=%0d", nw[k]), sv[k], mr[k] > 0);
                chk($sformatf("sout n=%0d", nw[k]), so[k], mr[k] > 0 && mw[k][mi[k]]);
                chk($sformatf("last n=%0d", nw[k]), sl[k], mr[k] > 0 && mi[k] == nw[k] - 1);
                chk($sformatf("load_ready n=%0d", nw[k]), lr[k], mr[k] == 0 || (mr[k] == 1 && sr));
            end
            if (sv[k]) vcnt[k]++;
            if (sv[k] && sr && capn[k] < 16) begin
                cap[k][capn[k]] = so[k];
                capn[k]++;
            end
            fire = mr[k] > 0 && sr;
            ld = lv && (mr[k] == 0 || (mr[k] == 1 && sr));
            if (r) begin
                mr[k] = 0;
                mi[k] = 0;
            end else begin
                if (fire) begin
                    mi[k]++;
                    mr[k]--;
                end
                if (ld) begin
                    mw[k] = (k == 1) ? {6'b0, dd[1:0]} : dd;
                    mi[k] = 0;
                    mr[k] = nw[k];
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mw[k] = '0;
            mi[k] = 0;
            mr[k] = 0;
        end
        clr();
        @(negedge clk);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        on = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        // single word
        clr();
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (9) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_bits", cap[0], 16'h00A5);
        chk("single_len", 16'(vcnt[0]), 16'd8);
        // back-to-back
        clr();
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (8) step(1'b1, 8'h3C, 1'b1, 1'b0);
        repeat (9) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("b2b_bits", cap[0], 16'h3CA5);
        chk("b2b_len", 16'(vcnt[0]), 16'd16);
        // backpressure on bit 2
        clr();
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (7) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_bits", cap[0], 16'h00A5);
        chk("bp_len", 16'(vcnt[0]), 16'd11);
        // load attempts while busy
        clr();
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (7) step(1'b1, 8'hFF, 1'b1, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("busy_bits", cap[0], 16'h00A5);
        // reset mid-word
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        clr();
        step(1'b1, 8'h01, 1'b1, 1'b0);
        repeat (9) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rst_reload_bits", cap[0], 16'h0001);
        chk("rst_reload_len", 16'(vcnt[0]), 16'd8);
        // minimum width back-to-back
        clr();
        step(1'b1, 8'h02, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h01, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("n2_bits", cap[1], 16'h0006);
        chk("n2_len", 16'(vcnt[1]), 16'd4);
        // random traffic
        repeat (600)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) == 0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
